// File: rtl/seq_square_isqrt_if.sv
// Handshake bundle for seq_square_isqrt.
//
// Valid/ready semantics (both channels): a transfer happens on a rising
// clock edge where valid and ready are both 1. The producer holds its
// payload stable while valid is high. Ready may be low at any time; the
// producer must not wait for ready before raising valid.
//
// Signals:
//   in_valid / in_ready : operand channel (source -> unit)
//   op                  : 0 = square, 1 = floor square root
//   in  [2W-1:0]        : operand (square mode uses in[W-1:0])
//   out_valid/out_ready : result channel (unit -> consumer)
//   out [2W-1:0]        : square, or {W'b0, root}
//   rem [W:0]           : sqrt remainder, 0 in square mode
//
// Modports:
//   slave  : the arithmetic unit
//   master : the environment (operand source + result consumer)
interface seq_square_isqrt_if #(
  parameter int W = 5
);
  logic           in_valid;
  logic           in_ready;
  logic           op;
  logic [2*W-1:0] in;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out;
  logic [W:0]     rem;

  modport slave (
    input  in_valid, op, in, out_ready,
    output in_ready, out_valid, out, rem
  );

  modport master (
    output in_valid, op, in, out_ready,
    input  in_ready, out_valid, out, rem
  );
endinterface

// File: rtl/seq_square_isqrt.sv
// Multi-cycle square / floor-square-root unit.
//
// One iteration per clock: square mode is an MSB-first shift-add over the
// W operand bits, sqrt mode is a restoring root that consumes two operand
// bits per clock. Both take exactly W clocks after acceptance.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   bus        : seq_square_isqrt_if.slave (operand/result handshakes)
//   dbg_state  : current FSM state (0 = IDLE, 1 = BUSY, 2 = DONE)
module seq_square_isqrt #(
  parameter  int W  = 5,
  localparam int CW = $clog2(W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_square_isqrt_if.slave     bus,
  output logic [1:0]            dbg_state
);

  localparam int RW = W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  // Latched operation and operand; the pins may change after acceptance.
  logic           op_q;
  logic [W-1:0]   a_q;     // square multiplicand
  logic [W-1:0]   m_q;     // square multiplier, shifted left to expose the next bit
  logic [2*W-1:0] opnd_q;  // sqrt operand, shifted left two bits per iteration
  logic [2*W-1:0] acc_q;
  logic [W+1:0]   r_q;
  logic [W-1:0]   root_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] out_q;
  logic [W:0]     rem_q;

  // Next-iteration values
  logic [2*W-1:0] acc_n;
  logic [W+1:0]   r_sh;
  logic [W+1:0]   t;
  logic [W+1:0]   r_n;
  logic [W-1:0]   root_n;
  logic           last;

  assign last = (cnt_q == CW'(1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_n = BUSY;
      BUSY:    if (last)          state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs decode straight from the state register, so a result
  // handoff and a new acceptance can never share an edge.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;
  assign bus.rem       = rem_q;
  assign dbg_state     = state;

  // ---------------- Iteration datapath ----------------
  always_comb begin
    acc_n = {acc_q[2*W-2:0], 1'b0} + (m_q[W-1] ? {{W{1'b0}}, a_q} : '0);

    // Before the shift r <= 2*root < 2^(k+1), so the shifted value always
    // fits in W+2 bits and the truncated top bits are zero.
    r_sh = (r_q << 2) | {{W{1'b0}}, opnd_q[2*W-1:2*W-2]};
    t    = {root_q, 2'b01};
    if (r_sh >= t) begin
      r_n    = r_sh - t;
      root_n = {root_q[W-2:0], 1'b1};
    end else begin
      r_n    = r_sh;
      root_n = {root_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= 1'b0;
      a_q    <= '0;
      m_q    <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      r_q    <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      rem_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q   <= bus.op;
            a_q    <= bus.in[W-1:0];
            m_q    <= bus.in[W-1:0];
            opnd_q <= bus.in;
            acc_q  <= '0;
            r_q    <= '0;
            root_q <= '0;
            cnt_q  <= CW'(W);
          end
        end
        BUSY: begin
          acc_q  <= acc_n;
          m_q    <= {m_q[W-2:0], 1'b0};
          opnd_q <= {opnd_q[2*W-3:0], 2'b00};
          r_q    <= r_n;
          root_q <= root_n;
          cnt_q  <= cnt_q - CW'(1);
          if (last) begin
            out_q <= op_q ? {{W{1'b0}}, root_n} : acc_n;
            // Final remainder is at most 2*root, so W+1 bits hold it.
            rem_q <= op_q ? RW'(r_n) : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_square_isqrt.sv
module tb_seq_square_isqrt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int accept_cyc = 0;

  logic [1:0] dbg5;
  logic [1:0] dbg16;

  seq_square_isqrt_if #(.W(5))  bus5 ();
  seq_square_isqrt_if #(.W(16)) bus16 ();

  seq_square_isqrt #(.W(5)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus5),
    .dbg_state (dbg5)
  );

  seq_square_isqrt #(.W(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus16),
    .dbg_state (dbg16)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send5(input logic op_i, input logic [9:0] in_i);
    int guard;
    guard = 0;
    while (bus5.in_ready !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL send5_in_ready_timeout: in_ready=%b required 1", bus5.in_ready);
    end
    bus5.in_valid = 1'b1;
    bus5.op       = op_i;
    bus5.in       = in_i;
    step();
    accept_cyc    = cyc;
    bus5.in_valid = 1'b0;
    // Scramble the pins: the result must come from the latched operand.
    bus5.op       = 1'($urandom);
    bus5.in       = 10'($urandom);
  endtask

  task automatic wait5(output int lat);
    lat = 0;
    while (bus5.out_valid !== 1'b1 && lat < 64) begin
      step();
      lat++;
    end
  endtask

  task automatic consume5();
    bus5.out_ready = 1'b1;
    step();
    bus5.out_ready = 1'b0;
  endtask

  function automatic int isqrt_ref(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus5.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", bus5.in_ready);
    end
    checks++;
    if (bus5.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b required 0", bus5.out_valid);
    end
    checks++;
    if (bus5.out !== 10'd0 || bus5.rem !== 6'd0) begin
      errors++; $display("FAIL reset_out_rem: got out=%0d rem=%0d required 0/0", bus5.out, bus5.rem);
    end
    checks++;
    if (dbg5 !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d required 0", dbg5);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_vectors();
    logic        ops  [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
    logic [9:0]  ins  [9] = '{31, 0, 1, 10'h3E5, 1023, 1000, 0, 1, 24};
    logic [9:0]  eout [9] = '{961, 0, 1, 25, 31, 31, 0, 1, 4};
    logic [5:0]  erem [9] = '{0, 0, 0, 0, 62, 39, 0, 0, 8};
    int lat;
    for (int i = 0; i < 9; i++) begin
      send5(ops[i], ins[i]);
      wait5(lat);
      checks++;
      if (lat !== 5) begin
        errors++; $display("FAIL vec_latency[%0d]: got %0d required 5", i, lat);
      end
      checks++;
      if (bus5.out !== eout[i]) begin
        errors++; $display("FAIL vec_out[%0d]: got %0d required %0d", i, bus5.out, eout[i]);
      end
      checks++;
      if (bus5.rem !== erem[i]) begin
        errors++; $display("FAIL vec_rem[%0d]: got %0d required %0d", i, bus5.rem, erem[i]);
      end
      consume5();
      checks++;
      if (bus5.in_ready !== 1'b1 || bus5.out_valid !== 1'b0) begin
        errors++; $display("FAIL vec_handoff[%0d]: got in_ready=%b out_valid=%b required 1/0",
                           i, bus5.in_ready, bus5.out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send5(1'b1, 10'd1000);
    wait5(lat);
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL bp_latency: got %0d required 5", lat);
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        bus5.in_valid = 1'b1;
        bus5.op       = 1'b0;
        bus5.in       = 10'd3;
      end
      step();
      bus5.in_valid = 1'b0;
      checks++;
      if (bus5.out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_out_valid[%0d]: got %b required 1", k, bus5.out_valid);
      end
      checks++;
      if (bus5.out !== 10'd31 || bus5.rem !== 6'd39) begin
        errors++; $display("FAIL bp_hold[%0d]: got out=%0d rem=%0d required 31/39", k, bus5.out, bus5.rem);
      end
      checks++;
      if (bus5.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready[%0d]: got %b required 0", k, bus5.in_ready);
      end
    end
    consume5();
    checks++;
    if (bus5.in_ready !== 1'b1 || bus5.out_valid !== 1'b0 || dbg5 !== 2'd0) begin
      errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b state=%0d required 1/0/0",
                         bus5.in_ready, bus5.out_valid, dbg5);
    end
    checks++;
    if (bus5.out !== 10'd31) begin
      errors++; $display("FAIL bp_out_kept: got %0d required 31", bus5.out);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    send5(1'b0, 10'd9);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dbg5 !== 2'd0 || bus5.in_ready !== 1'b1 || bus5.out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl: got state=%0d in_ready=%b out_valid=%b required 0/1/0",
                         dbg5, bus5.in_ready, bus5.out_valid);
    end
    checks++;
    if (bus5.out !== 10'd0 || bus5.rem !== 6'd0) begin
      errors++; $display("FAIL midrst_clear: got out=%0d rem=%0d required 0/0", bus5.out, bus5.rem);
    end
    send5(1'b0, 10'd7);
    wait5(lat);
    checks++;
    if (lat !== 5 || bus5.out !== 10'd49) begin
      errors++; $display("FAIL midrst_after: got lat=%0d out=%0d required 5/49", lat, bus5.out);
    end
    consume5();
  endtask

  task automatic test_back_to_back();
    int lat;
    int prev;
    int root;
    prev = -1;
    bus5.out_ready = 1'b1;
    for (int i = 0; i < 32 + 1024; i++) begin
      logic       op_i;
      logic [9:0] in_i;
      logic [9:0] e_out;
      logic [5:0] e_rem;
      op_i = (i >= 32);
      in_i = op_i ? 10'(i - 32) : 10'(i);
      if (op_i) begin
        root  = isqrt_ref(int'(in_i));
        e_out = 10'(root);
        e_rem = 6'(int'(in_i) - root * root);
      end else begin
        e_out = 10'(int'(in_i) * int'(in_i));
        e_rem = 6'd0;
      end
      send5(op_i, in_i);
      if (prev >= 0) begin
        checks++;
        if (accept_cyc - prev !== 7) begin
          errors++; $display("FAIL b2b_spacing[%0d]: got %0d required 7", i, accept_cyc - prev);
        end
      end
      prev = accept_cyc;
      wait5(lat);
      checks++;
      if (lat !== 5) begin
        errors++; $display("FAIL b2b_latency[%0d]: got %0d required 5", i, lat);
      end
      checks++;
      if (bus5.out !== e_out || bus5.rem !== e_rem) begin
        errors++; $display("FAIL b2b_result[%0d] op=%0d in=%0d: got out=%0d rem=%0d required %0d/%0d",
                           i, op_i, in_i, bus5.out, bus5.rem, e_out, e_rem);
      end
    end
    step();
    bus5.out_ready = 1'b0;
  endtask

  task automatic test_w16();
    int guard;
    int lat;
    bus16.out_ready = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic        op_i;
      logic [31:0] in_i;
      longint      x;
      longint      root;
      longint      sq;
      op_i = (i < 4) ? 1'(i) : 1'($urandom);
      // Boundary operands first, then random ones.
      if (i < 2)      in_i = 32'hFFFF_FFFF;
      else if (i < 4) in_i = 32'd0;
      else            in_i = $urandom;
      guard = 0;
      while (bus16.in_ready !== 1'b1 && guard < 50) begin
        step();
        guard++;
      end
      bus16.in_valid = 1'b1;
      bus16.op       = op_i;
      bus16.in       = in_i;
      step();
      bus16.in_valid = 1'b0;
      bus16.in       = $urandom;
      bus16.op       = 1'($urandom);
      lat = 0;
      while (bus16.out_valid !== 1'b1 && lat < 64) begin
        step();
        lat++;
      end
      checks++;
      if (lat !== 16) begin
        errors++; $display("FAIL w16_latency[%0d]: got %0d required 16", i, lat);
      end
      if (op_i == 1'b0) begin
        sq = longint'(in_i[15:0]) * longint'(in_i[15:0]);
        checks++;
        if (longint'(bus16.out) !== sq || bus16.rem !== 17'd0) begin
          errors++; $display("FAIL w16_square[%0d] in=%0d: got out=%0d rem=%0d required %0d/0",
                             i, in_i[15:0], bus16.out, bus16.rem, sq);
        end
      end else begin
        x    = longint'(in_i);
        root = longint'(bus16.out);
        checks++;
        if (root * root > x || (root + 1) * (root + 1) <= x ||
            longint'(bus16.rem) !== x - root * root) begin
          errors++; $display("FAIL w16_sqrt[%0d] in=%0d: got root=%0d rem=%0d", i, x, root, bus16.rem);
        end
      end
      bus16.out_ready = 1'b1;
      step();
      bus16.out_ready = 1'b0;
    end
  endtask

  initial begin
    bus5.in_valid   = 1'b0;
    bus5.op         = 1'b0;
    bus5.in         = '0;
    bus5.out_ready  = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.op        = 1'b0;
    bus16.in        = '0;
    bus16.out_ready = 1'b0;

    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_w16();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
